// File: rtl/alu_32bit.sv
// 32-bit MIPS datapath ALU: AND/OR/ADD/SUB/XOR with carry-out and zero flags.
// Latency: one clock; a, b and alu_ctr sampled at a rising edge, results registered at that edge.
// No backpressure: accepts new operands every cycle, one result per cycle, no stall.
module alu_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] r,
  output logic             c_out,
  output logic             z,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_ctr
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  // Adder operand and sum: SUB reuses the one adder with b inverted and carry-in of 1.
  logic             sub_sel;
  logic [WIDTH-1:0] b_add;
  logic [WIDTH:0]   sum;

  // Next-state result and carry before the output register.
  logic [WIDTH-1:0] r_nxt;
  logic             c_nxt;

  // Shared adder: a + b for ADD, a + ~b + 1 for SUB; the top bit is the carry out of the MSB.
  always_comb begin
    sub_sel = (alu_ctr == OP_SUB);
    b_add   = sub_sel ? ~b : b;
    sum     = {1'b0, a} + {1'b0, b_add} + {{WIDTH{1'b0}}, sub_sel};
  end

  // Operation select; unused codes give a clean zero result so nothing undefined reaches the flags.
  always_comb begin
    r_nxt = '0;
    c_nxt = 1'b0;
    case (alu_ctr)
      OP_AND: r_nxt = a & b;
      OP_OR:  r_nxt = a | b;
      OP_ADD: begin
        r_nxt = sum[WIDTH-1:0];
        c_nxt = sum[WIDTH];
      end
      OP_SUB: begin
        r_nxt = sum[WIDTH-1:0];
        c_nxt = sum[WIDTH];
      end
      OP_XOR: r_nxt = a ^ b;
      default: begin
        r_nxt = '0;
        c_nxt = 1'b0;
      end
    endcase
  end

  // Output register; zero flag is derived from the next-state result so it lines up with r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r     <= '0;
      c_out <= 1'b0;
      z     <= 1'b1;
    end else begin
      r     <= r_nxt;
      c_out <= c_nxt;
      z     <= (r_nxt == '0);
    end
  end

endmodule

// File: tb/tb_alu_32bit.sv
// Directed bench for alu_32bit: reset, each operation, wrap/carry edges, unused codes.
// Each step drives one vector right after a check and checks it one edge later.
// Back-to-back steps change the opcode every cycle with no idle cycles.
module tb_alu_32bit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] r;
  logic        c_out;
  logic        z;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  alu_ctr;

  int n_total = 0;
  int n_pass  = 0;

  alu_32bit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .r       (r),
    .c_out   (c_out),
    .z       (z),
    .a       (a),
    .b       (b),
    .alu_ctr (alu_ctr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] er, input logic ec, input logic ez);
    chk({tag, ".r"}, r, er);
    chk({tag, ".c_out"}, {31'd0, c_out}, {31'd0, ec});
    chk({tag, ".z"}, {31'd0, z}, {31'd0, ez});
  endtask

  // Drive one vector, let one rising edge register it, check just after the edge.
  task automatic step(input string tag, input logic [2:0] op, input logic [31:0] va,
                      input logic [31:0] vb, input logic [31:0] er, input logic ec,
                      input logic ez);
    a       = va;
    b       = vb;
    alu_ctr = op;
    @(posedge clk);
    #1;
    chk_out(tag, er, ec, ez);
  endtask

  initial begin
    rst     = 1'b1;
    a       = 32'd0;
    b       = 32'd0;
    alu_ctr = 3'b010;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset_hold", 32'd0, 1'b0, 1'b1);

    // Release reset away from an edge, then produce a nonzero result.
    rst = 1'b0;
    step("add_after_reset", 3'b010, 32'd10, 32'd30, 32'd40, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle clears outputs without any clock edge.
    #3;
    rst = 1'b1;
    #1;
    chk_out("async_reset", 32'd0, 1'b0, 1'b1);
    // Pending vector under reset must be discarded across an edge.
    a = 32'd7; b = 32'd9; alu_ctr = 3'b010;
    @(posedge clk);
    #1;
    chk_out("reset_discard", 32'd0, 1'b0, 1'b1);
    rst = 1'b0;
    step("add_10_30", 3'b010, 32'd10, 32'd30, 32'd40, 1'b0, 1'b0);

    // Logical ops
    step("and_10_30", 3'b000, 32'd10, 32'd30, 32'd10, 1'b0, 1'b0);
    step("and_0_20",  3'b000, 32'd0,  32'd20, 32'd0,  1'b0, 1'b1);
    step("or_10_30",  3'b001, 32'd10, 32'd30, 32'd30, 1'b0, 1'b0);
    step("or_0_20",   3'b001, 32'd0,  32'd20, 32'd20, 1'b0, 1'b0);
    step("and_mixed", 3'b000, 32'hF0F0_1234, 32'hFF00_FF0F, 32'hF000_1204, 1'b0, 1'b0);
    step("or_mixed",  3'b001, 32'hF0F0_0000, 32'h0F0F_0001, 32'hFFFF_0001, 1'b0, 1'b0);

    // Arithmetic
    step("add_0_20",    3'b010, 32'd0,   32'd20, 32'd20,        1'b0, 1'b0);
    step("sub_10_30",   3'b110, 32'd10,  32'd30, 32'hFFFF_FFEC, 1'b0, 1'b0);
    step("sub_0_20",    3'b110, 32'd0,   32'd20, 32'hFFFF_FFEC, 1'b0, 1'b0);
    step("sub_100_99",  3'b110, 32'd100, 32'd99, 32'd1,         1'b1, 1'b0);
    step("add_carry",   3'b010, 32'h8000_0001, 32'h8000_0002, 32'd3, 1'b1, 1'b0);

    // XOR
    step("xor_10_30", 3'b111, 32'd10, 32'd30, 32'd20, 1'b0, 1'b0);
    step("xor_0_20",  3'b111, 32'd0,  32'd20, 32'd20, 1'b0, 1'b0);
    step("xor_20_20", 3'b111, 32'd20, 32'd20, 32'd0,  1'b0, 1'b1);
    step("xor_ones",  3'b111, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 1'b0);

    // Wrap and carry edges
    step("add_wrap",   3'b010, 32'hFFFF_FFFF, 32'd1, 32'd0,         1'b1, 1'b1);
    step("sub_5_5",    3'b110, 32'd5,         32'd5, 32'd0,         1'b1, 1'b1);
    step("add_ovf",    3'b010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0);
    step("sub_0_1",    3'b110, 32'd0,         32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Unused codes, each following a nonzero result
    step("pre_011",  3'b001, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
    step("op_011",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    step("pre_100",  3'b010, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b1, 1'b0);
    step("op_100",   3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    step("pre_101",  3'b111, 32'd5, 32'd3, 32'd6, 1'b0, 1'b0);
    step("op_101",   3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);

    // Back-to-back opcode changes every cycle
    step("b2b_sub", 3'b110, 32'd50,  32'd8,  32'd42,  1'b1, 1'b0);
    step("b2b_and", 3'b000, 32'hFF,  32'h0F, 32'h0F,  1'b0, 1'b0);
    step("b2b_add", 3'b010, 32'd200, 32'd55, 32'd255, 1'b0, 1'b0);
    step("b2b_xor", 3'b111, 32'hAA,  32'h55, 32'hFF,  1'b0, 1'b0);
    step("b2b_or",  3'b001, 32'd0,   32'd0,  32'd0,   1'b0, 1'b1);
    step("b2b_sub2",3'b110, 32'd3,   32'd4,  32'hFFFF_FFFF, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
